// File: rtl/motor_bridge_drv.sv
// motor_bridge_drv
//   Turns the 2-bit obstacle-avoidance motor command into direction and PWM
//   enable signals for a dual H-bridge. Duty ramps up and down between
//   commands. A dead-time interval is inserted before a wheel is re-driven
//   from rest or reversed.
//
//   Ports
//     clk   system clock
//     rst   asynchronous, active-low reset
//     cmd   motor command: 11 fwd, 10 pivot left, 01 pivot right, 00 stop
//     in1   left bridge A          in2  left bridge B
//     in3   right bridge A         in4  right bridge B
//     ena   left PWM enable        enb  right PWM enable
//     busy  high while ramping or in dead-time
//
//   Build option
//     MOTOR_BRAKE_EN  when defined, STOP drives active short-brake
//                     (in1..in4 = 1, ena = enb = 1). Otherwise STOP coasts
//                     with all outputs at 0.
module motor_bridge_drv #(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_MAX   = 900,
  parameter int RAMP_STEP  = 10,
  parameter int RAMP_TICK  = 50000,
  parameter int DEAD_CYC   = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cmd,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       ena,
  output logic       enb,
  output logic       busy
);

  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int TW = (RAMP_TICK > 1) ? $clog2(RAMP_TICK) : 1;
  localparam int KW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [DW-1:0] DUTY_MAX_C = DW'(DUTY_MAX);
  localparam logic [DW-1:0] STEP_C     = DW'(RAMP_STEP);
  localparam logic [DW-1:0] PWM_LAST   = DW'(PWM_PERIOD - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(RAMP_TICK - 1);
  localparam logic [KW-1:0] DEAD_LAST  = KW'(DEAD_CYC - 1);

  typedef enum logic [2:0] {
    ST_STOP,
    ST_DEAD,
    ST_RAMP_UP,
    ST_RUN,
    ST_RAMP_DN
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      cmd_q;
  logic [1:0]      cur_cmd;
  logic [DW-1:0]   duty, duty_sh, pwm_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [KW-1:0]   dead_cnt;
  logic            tick, dead_done, stay;
  logic [DW:0]     up_sum;
  logic [DW-1:0]   duty_up, duty_dn;
  logic [3:0]      dir_d;
  logic            en_d, busy_d;

  assign tick      = (tick_cnt == TICK_LAST);
  assign dead_done = (dead_cnt == DEAD_LAST);
  assign stay      = (state_nxt == state);

  // Saturating ramp arithmetic. The sum is one bit wider so it cannot wrap.
  assign up_sum  = {1'b0, duty} + (DW + 1)'(RAMP_STEP);
  assign duty_up = (up_sum >= (DW + 1)'(DUTY_MAX)) ? DUTY_MAX_C : up_sum[DW-1:0];
  assign duty_dn = (duty <= STEP_C) ? '0 : duty - STEP_C;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cmd_q <= 2'b00;
    else      cmd_q <= cmd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_STOP;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_STOP:    if (cmd_q != 2'b00) state_nxt = ST_DEAD;
      ST_DEAD: begin
        if (cmd_q == 2'b00) state_nxt = ST_STOP;
        else if (dead_done) state_nxt = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (cmd_q != cur_cmd)        state_nxt = ST_RAMP_DN;
        else if (duty == DUTY_MAX_C) state_nxt = ST_RUN;
      end
      ST_RUN:     if (cmd_q != cur_cmd) state_nxt = ST_RAMP_DN;
      ST_RAMP_DN: begin
        if (cmd_q == cur_cmd) state_nxt = ST_RAMP_UP;
        else if (duty == '0)  state_nxt = (cmd_q == 2'b00) ? ST_STOP : ST_DEAD;
      end
      default:    state_nxt = ST_STOP;
    endcase
  end

  // Ramp/dead timers, duty and latched direction. The tick counter restarts
  // on any state change, so the first step of a ramp is a full tick away.
  // A step is not applied on a cycle that also leaves the state.
  // NOTE: every counter has an async reset so a mid-run reset restarts
  // cleanly from STOP with no stale timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      dead_cnt <= '0;
      duty     <= '0;
      cur_cmd  <= 2'b00;
    end else begin
      if (!stay || tick) tick_cnt <= '0;
      else               tick_cnt <= tick_cnt + 1'b1;

      if (state_nxt == ST_DEAD && state != ST_DEAD) dead_cnt <= '0;
      else if (state == ST_DEAD)                    dead_cnt <= dead_cnt + 1'b1;

      unique case (state)
        ST_STOP:    duty <= '0;
        ST_RAMP_UP: if (tick && stay) duty <= duty_up;
        ST_RUN:     duty <= DUTY_MAX_C;
        ST_RAMP_DN: if (tick && stay) duty <= duty_dn;
        default:    duty <= duty;
      endcase

      if (state == ST_DEAD && state_nxt == ST_RAMP_UP) cur_cmd <= cmd_q;
    end
  end

  // PWM carrier. The shadow duty changes only at the period boundary, so a
  // ramp step never produces a truncated or doubled pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      duty_sh <= '0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      if (pwm_cnt == PWM_LAST) duty_sh <= duty;
    end
  end

  always_comb begin
    dir_d  = 4'b0000;
    en_d   = 1'b0;
    busy_d = 1'b0;
    unique case (state)
      ST_STOP: begin
`ifdef MOTOR_BRAKE_EN
        dir_d = 4'b1111;
        en_d  = 1'b1;
`else
        dir_d = 4'b0000;
        en_d  = 1'b0;
`endif
      end
      ST_DEAD: busy_d = 1'b1;
      ST_RAMP_UP, ST_RUN, ST_RAMP_DN: begin
        busy_d = (state != ST_RUN);
        en_d   = (pwm_cnt < duty_sh);
        unique case (cur_cmd)
          2'b11:   dir_d = 4'b1010;
          2'b10:   dir_d = 4'b0110;
          2'b01:   dir_d = 4'b1001;
          default: dir_d = 4'b0000;
        endcase
      end
      default: ;
    endcase
  end

  // Registered outputs: glitch-free to the bridge, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {in1, in2, in3, in4} <= 4'b0000;
      ena  <= 1'b0;
      enb  <= 1'b0;
      busy <= 1'b0;
    end else begin
      {in1, in2, in3, in4} <= dir_d;
      ena  <= en_d;
      enb  <= en_d;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_motor_bridge_drv.sv
// tb_motor_bridge_drv
//   Directed bench for motor_bridge_drv with small timing parameters.
//   A queue holds the expected duty steps: the stimulus pushes them and a
//   negedge monitor pops them as the duty register changes. The monitor also
//   checks the tick spacing between steps. Pin, enable, busy and dead-time
//   checks are made inline. Both brake and coast builds are handled.
module tb_motor_bridge_drv;

  localparam int PWM_PERIOD = 10;
  localparam int DUTY_MAX   = 8;
  localparam int RAMP_STEP  = 2;
  localparam int RAMP_TICK  = 4;
  localparam int DEAD_CYC   = 3;

`ifdef MOTOR_BRAKE_EN
  localparam logic [3:0] STOP_PINS = 4'b1111;
  localparam logic       STOP_EN   = 1'b1;
`else
  localparam logic [3:0] STOP_PINS = 4'b0000;
  localparam logic       STOP_EN   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic       in1, in2, in3, in4, ena, enb, busy;
  logic [3:0] pins;

  assign pins = {in1, in2, in3, in4};

  motor_bridge_drv #(
    .PWM_PERIOD(PWM_PERIOD),
    .DUTY_MAX  (DUTY_MAX),
    .RAMP_STEP (RAMP_STEP),
    .RAMP_TICK (RAMP_TICK),
    .DEAD_CYC  (DEAD_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cmd (cmd),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .ena (ena),
    .enb (enb),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int duty;
    bit chk_gap;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int duty, input bit chk_gap);
    exp_t e;
    e.duty    = duty;
    e.chk_gap = chk_gap;
    exp_q.push_back(e);
  endtask

  task automatic push_ramp_up();
    push(2, 1'b0); push(4, 1'b1); push(6, 1'b1); push(8, 1'b1);
  endtask

  task automatic push_ramp_dn();
    push(6, 1'b0); push(4, 1'b1); push(2, 1'b1); push(0, 1'b1);
  endtask

  // Duty scoreboard monitor.
  int   cyc       = 0;
  int   last_chg  = 0;
  int   prev_duty = 0;
  int   cur_duty;
  exp_t mon_e;

  always @(negedge clk) begin
    cyc++;
    cur_duty = int'(dut.duty);
    if (cur_duty != prev_duty) begin
      if (exp_q.size() == 0) begin
        check("duty_unexpected", cur_duty, prev_duty);
      end else begin
        mon_e = exp_q.pop_front();
        check("duty_step", cur_duty, mon_e.duty);
        if (mon_e.chk_gap) check("tick_gap", cyc - last_chg, RAMP_TICK);
      end
      last_chg  = cyc;
      prev_duty = cur_duty;
    end
  end

  // Wait for busy to rise, then run until it falls. Count the cycles that
  // show the dead-time pattern (busy with every bridge output low).
  task automatic run_to_idle(input string tag, input int exp_dead);
    int n    = 0;
    int dead = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_rise"}, busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      if (pins == 4'b0000 && !ena && !enb) dead++;
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_dead_len"}, dead, exp_dead);
  endtask

  task automatic wait_duty(input string tag, input int value, input int budget);
    int n = 0;
    while (int'(dut.duty) != value && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, dut.duty, value);
  endtask

  task automatic count_en(input int cycles, output int na, output int nb);
    na = 0;
    nb = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ena === 1'b1) na++;
      if (enb === 1'b1) nb++;
    end
  endtask

  initial begin
    int na, nb;

    // Reset: every output low.
    rst = 1'b0;
    cmd = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_pins", pins, 0);
    check("rst_en", {ena, enb}, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;

    // Idle in STOP with cmd = 00.
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clk);
      check("stop_pins", pins, STOP_PINS);
      check("stop_ena", ena, STOP_EN);
      check("stop_enb", enb, STOP_EN);
      check("stop_busy", busy, 0);
    end
    check("stop_duty", dut.duty, 0);

    // STOP -> forward: dead-time, then ramp up to RUN.
    push_ramp_up();
    cmd = 2'b11;
    run_to_idle("fwd_start", DEAD_CYC);
    check("fwd_pins", pins, 4'b1010);
    check("fwd_q_empty", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    count_en(2 * PWM_PERIOD, na, nb);
    check("run_ena_count", na, 2 * DUTY_MAX);
    check("run_enb_count", nb, 2 * DUTY_MAX);

    // Forward -> pivot left: ramp down, dead-time, ramp up reversed.
    push_ramp_dn();
    push_ramp_up();
    cmd = 2'b10;
    repeat (4) @(negedge clk);
    check("fl_dn_pins", pins, 4'b1010);
    check("fl_dn_busy", busy, 1);
    run_to_idle("fwd_to_left", DEAD_CYC);
    check("left_pins", pins, 4'b0110);
    check("left_q_empty", exp_q.size(), 0);

    // Back to forward for the resume test.
    push_ramp_dn();
    push_ramp_up();
    cmd = 2'b11;
    run_to_idle("left_to_fwd", DEAD_CYC);
    check("fwd2_pins", pins, 4'b1010);

    // Ramp down from forward, resume at duty 4 without dead-time.
    push(6, 1'b0);
    push(4, 1'b1);
    cmd = 2'b10;
    wait_duty("resume_reach4", 4, 50);
    cmd = 2'b11;
    push(6, 1'b0);
    push(8, 1'b1);
    repeat (2) @(negedge clk);
    check("resume_pins_mid", pins, 4'b1010);
    run_to_idle("resume", 0);
    check("resume_pins", pins, 4'b1010);
    check("resume_q_empty", exp_q.size(), 0);

    // Forward -> stop: ramp to 0, STOP without dead-time.
    push_ramp_dn();
    cmd = 2'b00;
    run_to_idle("fwd_to_stop", 0);
    check("stop2_pins", pins, STOP_PINS);
    check("stop2_busy", busy, 0);
    count_en(PWM_PERIOD, na, nb);
    check("stop2_ena_count", na, STOP_EN ? PWM_PERIOD : 0);
    check("stop2_enb_count", nb, STOP_EN ? PWM_PERIOD : 0);
    check("stop2_q_empty", exp_q.size(), 0);

    // Reset in mid RAMP_UP: outputs clear asynchronously, then the full
    // sequence repeats.
    push(2, 1'b0);
    cmd = 2'b11;
    wait_duty("rst_reach2", 2, 40);
    push(0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_pins", pins, 0);
    check("async_rst_en", {ena, enb}, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_duty", dut.duty, 0);
    repeat (3) @(negedge clk);
    push_ramp_up();
    rst = 1'b1;
    run_to_idle("after_rst", DEAD_CYC);
    check("after_rst_pins", pins, 4'b1010);
    check("after_rst_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
